// File: rtl/adc_scan_sequencer.sv
// Multi-channel ADC scan engine: steps the analog mux over enabled channels,
// triggers conversions and queues {channel, sample} results in a FWFT FIFO.
module adc_scan_sequencer #(
  parameter int NUM_CH         = 8,
  parameter int ADC_BITS       = 12,
  parameter int FIFO_DEPTH     = 16,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int CH_W = $clog2(NUM_CH),
  localparam int LW   = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 scan_start,
  input  logic                 scan_stop,
  input  logic [NUM_CH-1:0]    chan_mask,
  input  logic                 continuous,
  output logic [CH_W-1:0]      amux_sel,
  output logic                 adc_trigger,
  input  logic                 adc_done,
  input  logic [ADC_BITS-1:0]  adc_data,
  input  logic                 fifo_rd,
  output logic [CH_W+ADC_BITS-1:0] fifo_rdata,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic [LW-1:0]        fifo_level,
  output logic                 busy,
  output logic                 overflow,
  output logic                 timeout,
  input  logic                 err_clr
);

  localparam int AW = LW - 1;
  localparam int DW = CH_W + ADC_BITS;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE, START, WAIT, STORE
  } state_t;

  state_t              state;
  logic [NUM_CH-1:0]   mask_q;
  logic [SW-1:0]       cnt;
  logic [TW-1:0]       timer;
  logic [ADC_BITS-1:0] sample;

  logic            low_ok, nxt_ok;
  logic [CH_W-1:0] low_ch, nxt_ch;
  logic            adv, adv_ok, adv_wrap;
  logic [CH_W-1:0] adv_ch;
  logic            wait_to;

  // lowest bit of the live mask, next bit above amux_sel in the latched mask
  always_comb begin
    low_ok = 1'b0;
    low_ch = '0;
    nxt_ok = 1'b0;
    nxt_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (chan_mask[i]) begin
        low_ok = 1'b1;
        low_ch = CH_W'(i);
      end
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i > int'(amux_sel))) begin
        nxt_ok = 1'b1;
        nxt_ch = CH_W'(i);
      end
    end
  end

  assign wait_to  = (state == WAIT) && !adc_done &&
                    (timer == TW'(TIMEOUT_CYCLES - 1));
  assign adv      = (state == STORE) || wait_to;
  assign adv_wrap = !nxt_ok;
  assign adv_ok   = nxt_ok || (continuous && low_ok);
  assign adv_ch   = nxt_ok ? nxt_ch : low_ch;
  assign busy     = (state != IDLE);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      mask_q      <= '0;
      cnt         <= '0;
      timer       <= '0;
      sample      <= '0;
      amux_sel    <= '0;
      adc_trigger <= 1'b0;
    end else if (scan_stop) begin
      state       <= IDLE;
      adc_trigger <= 1'b0;
    end else if (adv) begin
      adc_trigger <= 1'b0;
      if (adv_wrap) mask_q <= chan_mask;
      if (adv_ok) begin
        state    <= SETTLE;
        amux_sel <= adv_ch;
        cnt      <= '0;
      end else begin
        state <= IDLE;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (scan_start && low_ok) begin
            mask_q   <= chan_mask;
            amux_sel <= low_ch;
            cnt      <= '0;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == SW'(SETTLE_CYCLES - 1)) state <= START;
          else cnt <= cnt + SW'(1);
        end
        START: begin
          adc_trigger <= 1'b1;
          timer       <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          adc_trigger <= 1'b0;
          if (adc_done) begin
            sample <= adc_data;
            state  <= STORE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          push, pop, wr_en, ovf_set, to_set;
  logic [LW-1:0] level_n;

  assign push    = (state == STORE) && !scan_stop;
  assign pop     = fifo_rd && !fifo_empty;
  assign wr_en   = push && (!fifo_full || pop);
  assign ovf_set = push && fifo_full && !pop;
  assign to_set  = wait_to && !scan_stop;

  always_comb begin
    level_n = fifo_level;
    if (wr_en && !pop) level_n = fifo_level + LW'(1);
    else if (!wr_en && pop) level_n = fifo_level - LW'(1);
  end

  always_ff @(posedge PCLK) begin
    if (wr_en) mem[wptr] <= {amux_sel, sample};
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      overflow   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (pop)   rptr <= rptr + AW'(1);
      fifo_level <= level_n;
      fifo_empty <= (level_n == '0);
      fifo_full  <= (level_n == LW'(FIFO_DEPTH));
      overflow   <= (overflow && !err_clr) || ovf_set;
      timeout    <= (timeout && !err_clr) || to_set;
    end
  end

  assign fifo_rdata = fifo_empty ? '0 : mem[rptr];

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer: scan order, timeout, overflow,
// stop, mask wrap and async reset.
module tb_adc_scan_sequencer;

  localparam int NUM_CH = 8;
  localparam int AB     = 12;
  localparam int CH_W   = 3;
  localparam int LW     = 5;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic              scan_start, scan_stop, continuous;
  logic [NUM_CH-1:0] chan_mask;
  logic [CH_W-1:0]   amux_sel;
  logic              adc_trigger, adc_done;
  logic [AB-1:0]     adc_data;
  logic              fifo_rd;
  logic [CH_W+AB-1:0] fifo_rdata;
  logic              fifo_empty, fifo_full;
  logic [LW-1:0]     fifo_level;
  logic              busy, overflow, timeout, err_clr;

  int checks   = 0;
  int failures = 0;
  int seq      = 0;

  adc_scan_sequencer dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .scan_start(scan_start), .scan_stop(scan_stop),
    .chan_mask(chan_mask), .continuous(continuous),
    .amux_sel(amux_sel), .adc_trigger(adc_trigger),
    .adc_done(adc_done), .adc_data(adc_data),
    .fifo_rd(fifo_rd), .fifo_rdata(fifo_rdata),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_level(fifo_level), .busy(busy),
    .overflow(overflow), .timeout(timeout),
    .err_clr(err_clr)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_scan();
    @(negedge PCLK) scan_start = 1'b1;
    @(negedge PCLK) scan_start = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge PCLK) err_clr = 1'b1;
    @(negedge PCLK) err_clr = 1'b0;
  endtask

  task automatic pop1();
    @(negedge PCLK) fifo_rd = 1'b1;
    @(negedge PCLK) fifo_rd = 1'b0;
  endtask

  task automatic wait_trig(string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge PCLK);
      if (adc_trigger) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic done_pulse(int dly, output logic [AB-1:0] d);
    repeat (dly - 1) @(negedge PCLK);
    d = AB'(12'h300 + seq);
    seq++;
    adc_data = d;
    adc_done = 1'b1;
    @(negedge PCLK) adc_done = 1'b0;
  endtask

  logic [AB-1:0] d0, d1, dx;

  initial begin
    PRESETn = 1'b0; scan_start = 0; scan_stop = 0; continuous = 0;
    chan_mask = '0; adc_done = 0; adc_data = '0; fifo_rd = 0; err_clr = 0;
    repeat (3) @(negedge PCLK);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_amux", 32'(amux_sel), 0);
    chk("rst_empty", 32'(fifo_empty), 1);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_rdata", 32'(fifo_rdata), 0);
    chk("rst_flags", {30'd0, overflow, timeout}, 0);
    PRESETn = 1'b1;

    // two-channel single scan, first trigger latency
    chan_mask = 8'b0010_0100;
    start_scan();
    repeat (4) @(negedge PCLK);
    chk("t1_trig_early", 32'(adc_trigger), 0);
    @(negedge PCLK);
    chk("t1_trig", 32'(adc_trigger), 1);
    chk("t1_amux0", 32'(amux_sel), 2);
    done_pulse(3, d0);
    wait_trig("t1_trig2");
    chk("t1_amux1", 32'(amux_sel), 5);
    done_pulse(3, d1);
    chk("t1_busy_store", 32'(busy), 1);
    @(negedge PCLK);
    chk("t1_busy_idle", 32'(busy), 0);
    chk("t1_level", 32'(fifo_level), 2);
    chk("t1_head0", 32'(fifo_rdata), {17'd0, 3'd2, d0});
    pop1();
    chk("t1_head1", 32'(fifo_rdata), {17'd0, 3'd5, d1});
    pop1();
    chk("t1_empty", 32'(fifo_empty), 1);

    // timeout on channel 0, channel 1 still converts
    chan_mask = 8'h03;
    start_scan();
    wait_trig("t2_trig0");
    repeat (254) @(negedge PCLK);
    chk("t2_to_early", 32'(timeout), 0);
    @(negedge PCLK);
    chk("t2_to_set", 32'(timeout), 1);
    chk("t2_nowrite", 32'(fifo_level), 0);
    wait_trig("t2_trig1");
    chk("t2_amux1", 32'(amux_sel), 1);
    done_pulse(3, dx);
    @(negedge PCLK);
    chk("t2_level", 32'(fifo_level), 1);
    chk("t2_head", 32'(fifo_rdata), {17'd0, 3'd1, dx});
    chk("t2_sticky", 32'(timeout), 1);
    pulse_clr();
    chk("t2_to_clr", 32'(timeout), 0);
    pop1();

    // continuous fill to overflow
    continuous = 1'b1;
    chan_mask  = 8'h01;
    start_scan();
    for (int k = 0; k < 17; k++) begin
      wait_trig("t3_trig");
      done_pulse(2, dx);
      if (k == 1) d1 = dx;
    end
    @(negedge PCLK);
    chk("t3_level", 32'(fifo_level), 16);
    chk("t3_full", 32'(fifo_full), 1);
    chk("t3_ovf", 32'(overflow), 1);
    pulse_clr();
    chk("t3_ovf_clr", 32'(overflow), 0);
    wait_trig("t3_trig_pp");
    @(negedge PCLK);
    adc_data = AB'(12'h300 + seq);
    seq++;
    adc_done = 1'b1;
    @(negedge PCLK);
    adc_done = 1'b0;
    fifo_rd  = 1'b1;
    @(negedge PCLK);
    fifo_rd  = 1'b0;
    chk("t3_pp_level", 32'(fifo_level), 16);
    chk("t3_pp_ovf", 32'(overflow), 0);
    chk("t3_pp_full", 32'(fifo_full), 1);
    chk("t3_pp_head", 32'(fifo_rdata), {17'd0, 3'd0, d1});
    scan_stop = 1'b1;
    @(negedge PCLK) scan_stop = 1'b0;
    chk("t3_stop", 32'(busy), 0);
    fifo_rd = 1'b1;
    repeat (16) @(negedge PCLK);
    fifo_rd = 1'b0;
    chk("t3_drain", 32'(fifo_level), 0);

    // stop during WAIT, late done ignored
    continuous = 1'b0;
    chan_mask  = 8'h10;
    start_scan();
    wait_trig("t4_trig");
    chk("t4_amux", 32'(amux_sel), 4);
    @(negedge PCLK) scan_stop = 1'b1;
    @(negedge PCLK) scan_stop = 1'b0;
    chk("t4_idle", 32'(busy), 0);
    adc_done = 1'b1;
    @(negedge PCLK) adc_done = 1'b0;
    @(negedge PCLK);
    chk("t4_nowrite", 32'(fifo_level), 0);
    chk("t4_still_idle", 32'(busy), 0);
    chk("t4_amux_keep", 32'(amux_sel), 4);

    // mask change applies only at the wrap; zero mask at wrap ends scan
    continuous = 1'b1;
    chan_mask  = 8'h03;
    start_scan();
    wait_trig("t5_trig0");
    chk("t5_amux0", 32'(amux_sel), 0);
    chan_mask = 8'h80;
    done_pulse(3, dx);
    wait_trig("t5_trig1");
    chk("t5_amux1", 32'(amux_sel), 1);
    done_pulse(3, dx);
    wait_trig("t5_trig7");
    chk("t5_amux7", 32'(amux_sel), 7);
    chan_mask = 8'h00;
    done_pulse(3, dx);
    chk("t5_busy_store", 32'(busy), 1);
    @(negedge PCLK);
    chk("t5_idle", 32'(busy), 0);
    chk("t5_level", 32'(fifo_level), 3);

    // async reset mid-scan with level 5
    chan_mask = 8'h01;
    start_scan();
    wait_trig("t6_trig0");
    done_pulse(2, dx);
    wait_trig("t6_trig1");
    done_pulse(2, dx);
    @(negedge PCLK);
    chk("t6_level5", 32'(fifo_level), 5);
    wait_trig("t6_trig2");
    #2 PRESETn = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_level", 32'(fifo_level), 0);
    chk("t6_rst_empty", 32'(fifo_empty), 1);
    chk("t6_rst_amux", 32'(amux_sel), 0);
    chk("t6_rst_trig", 32'(adc_trigger), 0);
    @(negedge PCLK);
    PRESETn   = 1'b1;
    chan_mask = 8'h00;
    start_scan();
    @(negedge PCLK);
    chk("t6_mask0", 32'(busy), 0);
    chk("t6_rdata0", 32'(fifo_rdata), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
